// File: rtl/player_motion_ctrl_pkg.sv
// Shared types and state encodings for the player motion controller.
package motion_pkg;

  typedef logic signed [7:0] delta_t;

  typedef enum logic [1:0] {
    MS_GROUND = 2'd0,
    MS_JUMP   = 2'd1,
    MS_FALL   = 2'd2
  } motion_state_e;

  localparam logic [1:0] ST_GROUND = 2'd0;
  localparam logic [1:0] ST_JUMP   = 2'd1;
  localparam logic [1:0] ST_FALL   = 2'd2;

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Button/collision inputs and position outputs of the motion controller.
interface player_motion_ctrl_if #(
  parameter int X_W     = 11,
  parameter int Y_W     = 10,
  parameter int SHIFT_W = 12
) ();

  logic               tick;
  logic               cen_b;
  logic               up_b;
  logic               left_b;
  logic               right_b;
  logic               down_b;
  logic               col_detected;
  logic               outbounds;
  logic               game_win;
  logic [X_W-1:0]     blkpos_x_out;
  logic [Y_W-1:0]     blkpos_y_out;
  logic [SHIFT_W-1:0] x_shift;
  logic               rst_col_det;
  logic [1:0]         motion_state;

  modport master (
    output tick, cen_b, up_b, left_b, right_b, down_b,
    output col_detected, outbounds, game_win,
    input  blkpos_x_out, blkpos_y_out, x_shift, rst_col_det, motion_state
  );

  modport slave (
    input  tick, cen_b, up_b, left_b, right_b, down_b,
    input  col_detected, outbounds, game_win,
    output blkpos_x_out, blkpos_y_out, x_shift, rst_col_det, motion_state
  );

endinterface

// File: rtl/player_motion_ctrl_axis_step.sv
// One axis: add a signed delta to an unsigned position, clamp to [lo, hi],
// and report the delta that was actually applied.
module axis_step
  import motion_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] i_pos,
  input  delta_t       i_delta,
  input  logic [W-1:0] i_lo,
  input  logic [W-1:0] i_hi,
  output logic [W-1:0] o_pos,
  output delta_t       o_applied
);

  logic signed [W:0] w_sum;
  logic signed [W:0] w_lo;
  logic signed [W:0] w_hi;
  logic        [W:0] w_diff;

  // One extra bit holds any in-range position plus or minus 128 without wrap.
  always_comb begin
    w_sum     = $signed({1'b0, i_pos}) + $signed({{(W-7){i_delta[7]}}, i_delta});
    w_lo      = $signed({1'b0, i_lo});
    w_hi      = $signed({1'b0, i_hi});
    if (w_sum < w_lo)      o_pos = i_lo;
    else if (w_sum > w_hi) o_pos = i_hi;
    else                   o_pos = w_sum[W-1:0];
    w_diff    = {1'b0, o_pos} - {1'b0, i_pos};
    o_applied = w_diff[7:0];
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Tick-driven GROUND/JUMP/FALL motion controller with exact collision revert.
module player_motion_ctrl
  import motion_pkg::*;
#(
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int SHIFT_W     = 12,
  parameter int MOVE_SPEED  = 6,
  parameter int GRAV        = 5,
  parameter int JUMP_TICKS  = 35,
  parameter int SPRITE      = 48,
  parameter int Y_MAX       = 864,
  parameter int SHIFT_MIN   = 10,
  parameter int SHIFT_MAX   = 3360,
  parameter int START_X     = 695,
  parameter int START_Y     = 400,
  parameter int START_SHIFT = 10
) (
  input logic                clk,
  input logic                rst,
  player_motion_ctrl_if.slave bus
);

  localparam int JC_W = $clog2(JUMP_TICKS + 1);

  localparam delta_t               D_MS   = delta_t'(MOVE_SPEED);
  localparam delta_t               D_GRAV = delta_t'(GRAV);
  localparam logic [JC_W-1:0]      JC_MAX = JC_W'(JUMP_TICKS);
  localparam logic [Y_W-1:0]       Y_LO   = '0;
  localparam logic [Y_W-1:0]       Y_HI   = Y_W'(Y_MAX - SPRITE);
  localparam logic [SHIFT_W-1:0]   SH_LO  = SHIFT_W'(SHIFT_MIN);
  localparam logic [SHIFT_W-1:0]   SH_HI  = SHIFT_W'(SHIFT_MAX - SPRITE);

  if (MOVE_SPEED + GRAV > 127) begin : g_bad_speed
    $error("MOVE_SPEED + GRAV must fit a signed 8-bit delta");
  end

  logic [Y_W-1:0]     r_y;
  logic [SHIFT_W-1:0] r_shift;
  logic [1:0]         r_state;
  logic [JC_W-1:0]    r_jc;
  delta_t             r_ldx;
  delta_t             r_ldy;
  logic               r_ack;

  delta_t             w_dx;
  delta_t             w_dy_move;
  logic [1:0]         w_state_move;
  logic [JC_W-1:0]    w_jc_move;
  logic               w_col;
  delta_t             w_dx_sel;
  delta_t             w_dy_sel;
  logic [Y_W-1:0]     w_y_next;
  logic [SHIFT_W-1:0] w_shift_next;
  delta_t             w_ldy_app;
  delta_t             w_ldx_app;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_dx         = '0;
    w_dy_move    = '0;
    w_state_move = r_state;
    w_jc_move    = r_jc;
    case ({bus.right_b, bus.left_b})
      2'b10:   w_dx = D_MS;
      2'b01:   w_dx = -D_MS;
      default: w_dx = '0;
    endcase
    case (r_state)
      ST_GROUND: begin
        if (bus.up_b) begin
          w_dy_move    = -D_MS;
          w_jc_move    = r_jc - JC_W'(1);
          w_state_move = ST_JUMP;
        end else if (w_dx != '0) begin
          w_dy_move    = D_GRAV;
          w_state_move = ST_FALL;
        end
      end
      ST_JUMP: begin
        if (bus.up_b && (r_jc != '0)) begin
          w_dy_move = -D_MS;
          w_jc_move = r_jc - JC_W'(1);
        end else begin
          w_dy_move    = D_GRAV;
          w_state_move = ST_FALL;
        end
      end
      default: begin
        w_dy_move    = bus.down_b ? (D_GRAV + D_MS) : D_GRAV;
        w_state_move = ST_FALL;
      end
    endcase
  end

  // A collision feeds the negated last delta through the same adders.
  assign w_col    = bus.tick & bus.col_detected;
  assign w_dx_sel = w_col ? -r_ldx : w_dx;
  assign w_dy_sel = w_col ? -r_ldy : w_dy_move;

  axis_step #(.W(Y_W)) u_y_step (
    .i_pos     (r_y),
    .i_delta   (w_dy_sel),
    .i_lo      (Y_LO),
    .i_hi      (Y_HI),
    .o_pos     (w_y_next),
    .o_applied (w_ldy_app)
  );

  axis_step #(.W(SHIFT_W)) u_shift_step (
    .i_pos     (r_shift),
    .i_delta   (w_dx_sel),
    .i_lo      (SH_LO),
    .i_hi      (SH_HI),
    .o_pos     (w_shift_next),
    .o_applied (w_ldx_app)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || bus.game_win || bus.outbounds) begin
      r_y     <= Y_W'(START_Y);
      r_shift <= SHIFT_W'(START_SHIFT);
      r_state <= ST_FALL;
      r_jc    <= JC_MAX;
      r_ldx   <= '0;
      r_ldy   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (bus.tick) begin
        if (bus.col_detected) begin
          r_ack <= 1'b1;
          if ((r_ldx != '0) || (r_ldy != '0)) begin
            r_y     <= w_y_next;
            r_shift <= w_shift_next;
            r_ldx   <= '0;
            r_ldy   <= '0;
            // Landing only when the reverted move was downward; otherwise head bump or wall.
            if (r_ldy > 0) begin
              r_state <= ST_GROUND;
              r_jc    <= JC_MAX;
            end else begin
              r_state <= ST_FALL;
              r_jc    <= '0;
            end
          end
        end else begin
          r_y     <= w_y_next;
          r_shift <= w_shift_next;
          r_ldx   <= w_ldx_app;
          r_ldy   <= w_ldy_app;
          r_state <= w_state_move;
          r_jc    <= w_jc_move;
        end
        if (bus.cen_b) r_jc <= JC_MAX;
      end
    end
  end

  assign bus.blkpos_x_out = X_W'(START_X);
  assign bus.blkpos_y_out = r_y;
  assign bus.x_shift      = r_shift;
  assign bus.rst_col_det  = r_ack;
  assign bus.motion_state = r_state;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed and randomized bench for player_motion_ctrl against an integer reference model.
module tb_player_motion_ctrl;

  localparam int MS    = 6;
  localparam int GR    = 5;
  localparam int JT    = 35;
  localparam int Y_TOP = 864 - 48;
  localparam int SH_LO = 10;
  localparam int SH_HI = 3360 - 48;
  localparam int ST_X  = 695;
  localparam int ST_Y  = 400;
  localparam int ST_SH = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  player_motion_ctrl_if #(.X_W(11), .Y_W(10), .SHIFT_W(12)) bus ();

  player_motion_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain integers, state 0=ground 1=jump 2=fall.
  int m_y, m_sh, m_st, m_jc, m_ldx, m_ldy, m_ack;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit t, col, ob, gw, r, up, dn, lf, rt, cen);
    int dx, dy, ny, ns;
    m_ack = 0;
    if (r || gw || ob) begin
      m_y = ST_Y; m_sh = ST_SH; m_st = 2; m_jc = JT; m_ldx = 0; m_ldy = 0;
    end else if (t) begin
      if (col) begin
        m_ack = 1;
        if (m_ldx != 0 || m_ldy != 0) begin
          m_y  -= m_ldy;
          m_sh -= m_ldx;
          if (m_ldy > 0) begin m_st = 0; m_jc = JT; end
          else           begin m_st = 2; m_jc = 0;  end
          m_ldx = 0; m_ldy = 0;
        end
      end else begin
        dx = (rt && !lf) ? MS : (lf && !rt) ? -MS : 0;
        dy = 0;
        if (m_st == 0) begin
          if (up)           begin dy = -MS; m_jc--; m_st = 1; end
          else if (dx != 0) begin dy = GR; m_st = 2; end
        end else if (m_st == 1) begin
          if (up && m_jc > 0) begin dy = -MS; m_jc--; end
          else                begin dy = GR; m_st = 2; end
        end else begin
          dy = GR + (dn ? MS : 0);
        end
        ny = clamp(m_y + dy, 0, Y_TOP);
        ns = clamp(m_sh + dx, SH_LO, SH_HI);
        m_ldy = ny - m_y;
        m_ldx = ns - m_sh;
        m_y = ny;
        m_sh = ns;
      end
      if (cen) m_jc = JT;
    end
  endtask

  task automatic step(input bit t, col, ob, gw, r, up, dn, lf, rt, cen);
    @(negedge clk);
    rst              = r;
    bus.tick         = t;
    bus.col_detected = col;
    bus.outbounds    = ob;
    bus.game_win     = gw;
    bus.up_b         = up;
    bus.down_b       = dn;
    bus.left_b       = lf;
    bus.right_b      = rt;
    bus.cen_b        = cen;
    model(t, col, ob, gw, r, up, dn, lf, rt, cen);
    @(posedge clk);
    #1;
    chk("y",     bus.blkpos_y_out, m_y);
    chk("shift", bus.x_shift,      m_sh);
    chk("x",     bus.blkpos_x_out, ST_X);
    chk("ack",   bus.rst_col_det,  m_ack);
    chk("state", bus.motion_state, m_st);
  endtask

  //                         t  col ob gw r  up dn lf rt cen
  task automatic idle();   step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic tk();     step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic coll();   step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic respawn(); step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    bit t, col, ob, gw, r, up, dn, lf, rt, cen;
    bus.tick = 0; bus.col_detected = 0; bus.outbounds = 0; bus.game_win = 0;
    bus.up_b = 0; bus.down_b = 0; bus.left_b = 0; bus.right_b = 0; bus.cen_b = 0;

    // Reset values
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("rst_y", bus.blkpos_y_out, ST_Y);
    chk("rst_state", bus.motion_state, 2);

    // Fall one tick, then collision lands on ground
    tk();
    chk("fall_y", bus.blkpos_y_out, 405);
    coll();
    chk("land_y", bus.blkpos_y_out, 400);
    chk("land_ack", bus.rst_col_det, 1);
    chk("land_state", bus.motion_state, 0);
    idle();
    chk("ack_one_clk", bus.rst_col_det, 0);

    // Jump with up held for 40 ticks
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      if (i == 34) chk("jump_apex", bus.blkpos_y_out, 190);
      if (i == 35) begin
        chk("jump_end_y", bus.blkpos_y_out, 195);
        chk("jump_end_state", bus.motion_state, 2);
      end
    end
    coll();
    chk("land2_y", bus.blkpos_y_out, 210);

    // Walk right off ground, collision reverts both axes
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("walk_shift", bus.x_shift, 16);
    chk("walk_y", bus.blkpos_y_out, 215);
    coll();
    chk("walk_rev_shift", bus.x_shift, 10);
    chk("walk_rev_y", bus.blkpos_y_out, 210);
    chk("walk_rev_state", bus.motion_state, 0);

    // Scroll to the upper clamp, back down to 12, then left clamp and exact revert
    for (int i = 0; i < 560; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("shift_max", bus.x_shift, SH_HI);
    chk("y_bottom", bus.blkpos_y_out, Y_TOP);
    for (int i = 0; i < 550; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("shift_12", bus.x_shift, 12);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("shift_min", bus.x_shift, SH_LO);
    coll();
    chk("shift_revert", bus.x_shift, 12);

    // Respawn mid-jump without a tick
    respawn();
    tk();
    coll();
    for (int i = 0; i < 50; i++) step(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    chk("cen_jump_y", bus.blkpos_y_out, 100);
    chk("cen_jump_state", bus.motion_state, 1);
    respawn();
    chk("respawn_y", bus.blkpos_y_out, ST_Y);
    chk("respawn_shift", bus.x_shift, ST_SH);
    chk("respawn_state", bus.motion_state, 2);
    tk();
    chk("respawn_fall", bus.blkpos_y_out, 405);

    // rst and game_win on a collision tick
    step(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("rstwin_y", bus.blkpos_y_out, ST_Y);
    chk("rstwin_ack", bus.rst_col_det, 0);
    idle();
    chk("rstwin_ack2", bus.rst_col_det, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      t   = ($urandom_range(0, 9) < 7);
      col = t && ($urandom_range(0, 9) < 2);
      ob  = ($urandom_range(0, 99) < 2);
      gw  = ($urandom_range(0, 199) == 0);
      r   = ($urandom_range(0, 199) == 0);
      up  = $urandom_range(0, 1);
      dn  = $urandom_range(0, 1);
      lf  = $urandom_range(0, 1);
      rt  = $urandom_range(0, 1);
      cen = ($urandom_range(0, 9) == 0);
      step(t, col, ob, gw, r, up, dn, lf, rt, cen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/player_motion_ctrl.md
# player_motion_ctrl

Parametrised, tick-driven player motion controller; successor to the fixed-constant movement logic in the game controller. Runs on the system clock with a one-cycle frame-tick enable and turns pushbuttons into sprite position and level scroll under an explicit GROUND/JUMP/FALL state machine. It reverts exactly the last applied move on a collision and handshakes the collision flag back to the draw controller. It sits between the button debouncers and the drawing/collision logic.

## Interface
- X_W, 11: width of blkpos_x_out
- Y_W, 10: width of blkpos_y_out
- SHIFT_W, 12: width of x_shift
- MOVE_SPEED, 6: pixels per tick per axis from buttons
- GRAV, 5: pixels per tick of gravity
- JUMP_TICKS, 35: maximum ticks of upward motion per jump
- SPRITE, 48: sprite edge in pixels
- Y_MAX, 864: screen height
- SHIFT_MIN, 10 / SHIFT_MAX, 3360: scroll limits
- START_X, 695 / START_Y, 400 / START_SHIFT, 10: spawn position
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-clk frame-rate enable (60 Hz)
- cen_b, up_b, left_b, right_b, down_b  in  1 each  debounced buttons, level-sensitive
- col_detected  in  1  draw controller reports overlap from the last move
- outbounds  in  1  player left playable area
- game_win  in  1  level complete
- blkpos_x_out  out  X_W  sprite x (constant START_X)
- blkpos_y_out  out  Y_W  sprite y
- x_shift  out  SHIFT_W  level scroll
- rst_col_det  out  1  one-clk acknowledge of a processed collision
- motion_state  out  2  current FSM state (debug)

## Operation
- States: GROUND=0, JUMP=1, FALL=2. Reset/respawn state: FALL.
- Jump counter jc: reloads to JUMP_TICKS on reset, on respawn, on entry to GROUND and on any tick with cen_b=1.
- Per tick, compute the proposed delta (dx, dy), signed, 8 bit. Parameter check: MOVE_SPEED+GRAV ≤ 127.
- dx: right_b alone gives +MOVE_SPEED, left_b alone gives −MOVE_SPEED, both or neither gives 0. Applies in every state.
- dy in GROUND:
  - up_b: dy=−MOVE_SPEED, jc−1, go to JUMP.
  - Otherwise, dx≠0: dy=+GRAV (ground probe), go to FALL.
  - Otherwise: dy=0, stay in GROUND.
- dy in JUMP:
  - up_b and jc>0: dy=−MOVE_SPEED, jc−1.
  - Otherwise: dy=+GRAV, go to FALL. down_b is ignored.
- dy in FALL: dy=+GRAV, plus MOVE_SPEED if down_b. Up is ignored.
- Clamp the applied result: x_shift to [SHIFT_MIN, SHIFT_MAX−SPRITE], y to [0, Y_MAX−SPRITE].
- Store the applied (post-clamp) delta as (ldx, ldy).
- Collision tick (col_detected=1 when tick=1): takes the place of movement.
  - Position −= (ldx, ldy), then (ldx, ldy) := 0.
  - Pulse rst_col_det.
  - If ldy>0: go to GROUND. Otherwise: go to FALL with jc=0 (head bump or wall).
  - A collision with ldx=ldy=0 only pulses the acknowledge.
- Respawn (outbounds or game_win, any cycle, tick not required):
  - Position := START, state FALL, jc reload, last delta 0, rst_col_det 0.
- Priority: rst > game_win > outbounds > col_detected > movement.
- Arithmetic: unsigned position plus sign-extended delta at width+1, then clamp. No wrap is possible.

## Timing
- Reset values:
  - blkpos_x_out=START_X, blkpos_y_out=START_Y, x_shift=START_SHIFT
  - rst_col_det=0, motion_state=2
- All outputs are registered and update on the clk edge that samples tick=1 (1-cycle latency).
- Inputs are ignored when tick=0, except rst, outbounds and game_win.
- rst_col_det is high exactly one clk, in the cycle after the collision tick. The draw controller clears col_detected before the next tick.
- col_detected still high at the next tick is treated as a new collision, with a zero delta, giving only an acknowledge pulse.
- Reset or respawn in the middle of a jump abandons the jump immediately.

## Structure
- Package motion_pkg:
  - state enum
  - delta_t (signed 8 bit)
  - state encodings
- Sub-module axis_step, instantiated twice (y and shift):
  - Inputs: position, signed delta, lo/hi bounds.
  - Outputs: clamped next position and applied delta.
  - Parameter: width.

## Test plan
- Reset, tick with no buttons: y goes 400→405 (FALL). Then col_detected at the next tick: y=400, rst_col_det pulse 1 clk, state GROUND.
- From GROUND, hold up_b for 40 ticks: y falls by 6 for 35 ticks (400→190), then state FALL and +5 per tick.
- From GROUND, hold right_b: tick 1 gives x_shift 10→16 and y+5. col_detected then gives x_shift=10, y restored, GROUND.
- Hold left_b at x_shift=12: x_shift clamps to 10. A following collision restores 12, an exact revert.
- In JUMP at y=100, assert outbounds without tick: next clk gives y=400, x_shift=10, state FALL, jc=35.
- Assert rst and game_win together during a collision tick: reset values, rst_col_det stays 0.
